mult_div_unit: RTL and testbench

Multi-cycle integer multiply/divide unit that sits directly downstream of the register file. It consumes the two read-port operands (rs, rt) and owns the architectural HI/LO registers. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO are exposed to the datapath write-back mux for MFHI/MFLO. Control stalls the pipeline while busy is high.

---
 rtl/mips_pkg.sv | 19 +
 rtl/md_sign_fix.sv | 35 +++
 rtl/mult_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default width.
package mips_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign helpers: operand magnitudes at latch time and result
// negation when the unit finishes.
module md_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   a_in,
    input  logic [XLEN-1:0]   b_in,
    input  logic              is_signed,
    output logic [XLEN-1:0]   a_mag,
    output logic [XLEN-1:0]   b_mag,
    output logic              a_neg,
    output logic              b_neg,
    input  logic [2*XLEN-1:0] raw,
    input  logic              wide,
    input  logic              neg_hi,
    input  logic              neg_lo,
    output logic [2*XLEN-1:0] fixed
);

    always_comb begin
        a_neg = is_signed & a_in[XLEN-1];
        b_neg = is_signed & b_in[XLEN-1];
        a_mag = a_neg ? -a_in : a_in;
        b_mag = b_neg ? -b_in : b_in;

        // A product is negated as one 2*XLEN value; quotient and remainder separately.
        if (wide) begin
            fixed = neg_hi ? -raw : raw;
        end else begin
            fixed[2*XLEN-1:XLEN] = neg_hi ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
            fixed[XLEN-1:0]      = neg_lo ? -raw[XLEN-1:0]      : raw[XLEN-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: one bit per cycle, then a sign-fix cycle.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int ITER = XLEN;
    localparam int CW   = $clog2(ITER);

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              is_div_q, is_div_d;
    logic              neg_hi_q, neg_hi_d;
    logic              neg_lo_q, neg_lo_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              op_signed;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              a_neg, b_neg;
    logic [2*XLEN-1:0] fixed;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;

    assign op_signed = (op == MD_MULT) || (op == MD_DIV);

    md_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .a_in      (rs_data),
        .b_in      (rt_data),
        .is_signed (op_signed),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .raw       (acc_q),
        .wide      (!is_div_q),
        .neg_hi    (neg_hi_q),
        .neg_lo    (neg_lo_q),
        .fixed     (fixed)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        // The upper accumulator half is the partial product or the running remainder.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            acc_d    = {{XLEN{1'b0}}, a_mag};
                            opb_d    = b_mag;
                            is_div_d = 1'b0;
                            neg_hi_d = a_neg ^ b_neg;
                            neg_lo_d = a_neg ^ b_neg;
                            cnt_d    = '0;
                            state_d  = MD_CALC;
                        end
                        MD_DIV, MD_DIVU: begin
                            opb_d    = b_mag;
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            state_d  = MD_CALC;
                            // A zero divisor yields the raw restoring result on the raw dividend.
                            if (rt_data == '0) begin
                                acc_d    = {{XLEN{1'b0}}, rs_data};
                                neg_hi_d = 1'b0;
                                neg_lo_d = 1'b0;
                            end else begin
                                acc_d    = {{XLEN{1'b0}}, a_mag};
                                neg_hi_d = a_neg;
                                neg_lo_d = a_neg ^ b_neg;
                            end
                        end
                        MD_MTHI: hi_d = rs_data;
                        MD_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            MD_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (!div_trial[XLEN]) begin
                        acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                hi_d    = fixed[2*XLEN-1:XLEN];
                lo_d    = fixed[XLEN-1:0];
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase

        busy_d = (state_d != MD_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// mult/div traffic compared against an arithmetic reference model.
module tb_mult_div_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checkCount = 0;
    int          failCount = 0;
    logic [31:0] expHi;
    logic [31:0] expLo;

    mult_div_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rsData),
        .rt_data (rtData),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op.
    function automatic void modelOp(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        eh = 32'h0;
        el = 32'h0;
        case (opc)
            MD_MULT: begin
                p  = 64'(longint'(sa) * longint'(sb));
                eh = p[63:32];
                el = p[31:0];
            end
            MD_MULTU: begin
                p  = 64'(a) * 64'(b);
                eh = p[63:32];
                el = p[31:0];
            end
            MD_DIV: begin
                if (b == 32'h0) begin
                    el = 32'hFFFFFFFF;
                    eh = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    el = 32'h80000000;
                    eh = 32'h0;
                end else begin
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                end
            end
            MD_DIVU: begin
                if (b == 32'h0) begin
                    el = 32'hFFFFFFFF;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Drives a request at the current negedge; returns at the following negedge.
    task automatic applyStimulus(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = opc;
        rsData = a;
        rtData = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic runMd(input string tag, input logic [2:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input bit injectMthi);
        int          busyCnt;
        bit          earlyDone;
        bit          holdBad;
        logic [31:0] oldHi, oldLo;
        oldHi     = expHi;
        oldLo     = expLo;
        modelOp(opc, a, b, expHi, expLo);
        busyCnt   = 0;
        earlyDone = 1'b0;
        holdBad   = 1'b0;
        applyStimulus(opc, a, b);
        while (busy === 1'b1 && busyCnt < 100) begin
            if (done !== 1'b0) earlyDone = 1'b1;
            if (hi !== oldHi || lo !== oldLo) holdBad = 1'b1;
            if (injectMthi && busyCnt == 5) begin
                start  = 1'b1;
                op     = MD_MTHI;
                rsData = 32'hAAAA0000;
            end else begin
                start  = 1'b0;
            end
            busyCnt++;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput({tag, "_busy_cycles"}, 64'(busyCnt), 64'd33);
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
        checkOutput({tag, "_no_early_done"}, 64'(earlyDone), 64'd0);
        checkOutput({tag, "_hilo_held"}, 64'(holdBad), 64'd0);
    endtask

    initial begin
        logic [2:0]  rOp;
        logic [31:0] rA, rB;

        rst    = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        rsData = 32'h0;
        rtData = 32'h0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        expHi  = 32'h0;
        expLo  = 32'h0;
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);

        runMd("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'h00000003, 1'b0);
        @(negedge clk);
        checkOutput("done_single_pulse", 64'(done), 64'd0);
        runMd("multu", MD_MULTU, 32'hFFFFFFFE, 32'h00000003, 1'b0);
        runMd("div_neg", MD_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        runMd("divu", MD_DIVU, 32'd100, 32'd7, 1'b0);
        runMd("divu_zero", MD_DIVU, 32'h12345678, 32'h0, 1'b0);
        runMd("div_zero", MD_DIV, 32'h87654321, 32'h0, 1'b0);
        runMd("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        runMd("mult_mthi_busy", MD_MULT, 32'h00012345, 32'hFFFF6789, 1'b1);

        @(negedge clk);
        applyStimulus(MD_MTLO, 32'h00000055, 32'h0);
        expLo = 32'h00000055;
        checkOutput("mtlo_lo", 64'(lo), 64'(expLo));
        checkOutput("mtlo_hi_kept", 64'(hi), 64'(expHi));
        checkOutput("mtlo_busy", 64'(busy), 64'd0);
        checkOutput("mtlo_done", 64'(done), 64'd0);

        applyStimulus(MD_MTHI, 32'hCAFEF00D, 32'h0);
        expHi = 32'hCAFEF00D;
        checkOutput("mthi_hi", 64'(hi), 64'(expHi));
        checkOutput("mthi_lo_kept", 64'(lo), 64'(expLo));

        applyStimulus(3'd7, 32'h11111111, 32'h22222222);
        @(negedge clk);
        checkOutput("undef_busy", 64'(busy), 64'd0);
        checkOutput("undef_hi", 64'(hi), 64'(expHi));
        checkOutput("undef_lo", 64'(lo), 64'(expLo));

        // The second request is issued in the done cycle of the first.
        runMd("b2b_first", MD_DIVU, 32'd1000, 32'd33, 1'b0);
        runMd("b2b_second", MD_MULTU, 32'hDEADBEEF, 32'h00001000, 1'b0);

        applyStimulus(MD_MULT, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        expHi = 32'h0;
        expLo = 32'h0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_hi", 64'(hi), 64'd0);
        checkOutput("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        checkOutput("abort_no_late_done", 64'(done), 64'd0);
        checkOutput("abort_still_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 24; i++) begin
            rOp = 3'($urandom_range(0, 3));
            rA  = $urandom;
            case ($urandom_range(0, 7))
                0:       rB = 32'h0;
                1, 2:    rB = 32'($urandom_range(1, 20));
                3:       rB = -32'($urandom_range(1, 20));
                default: rB = $urandom;
            endcase
            runMd($sformatf("rand%0d", i), rOp, rA, rB, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
